// File: rtl/xc_aessub_pkg.sv
// Shared definitions for the XCrypto aessub unit: FSM encoding, operand
// byte gather, result packing and GF(2^8) S-box arithmetic.
package xc_aessub_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef logic [3:0][7:0] byte4_t;

   function automatic byte4_t gather(input logic [31:0] rs1, input logic [31:0] rs2);
      return {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]};
   endfunction

   function automatic logic [31:0] pack_rot(input byte4_t u, input logic rot);
      return rot ? {u[0], u[3], u[2], u[1]} : {u[3], u[2], u[1], u[0]};
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = a;
      for (int k = 1; k < 8; k++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] aff_fwd(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] aff_inv(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

endpackage

// File: rtl/xc_aessub_if.sv
// Request/response bundle between the execute stage and the aessub unit.
interface xc_aessub_if;
   logic        valid;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        enc;
   logic        rot;
   logic        ready;
   logic [31:0] result;

   modport master (output valid, rs1, rs2, enc, rot, input ready, result);
   modport slave  (input valid, rs1, rs2, enc, rot, output ready, result);
endinterface

// File: rtl/xc_aessub_sbox.sv
// Combinational AES S-box lane; enc selects forward or inverse table.
module xc_aessub_sbox
   import xc_aessub_pkg::*;
(
   input  logic       enc,
   input  logic [7:0] din,
   output logic [7:0] dout
);

   always_comb begin
      dout = enc ? aff_fwd(gf_inv(din)) : gf_inv(aff_inv(din));
   end

endmodule

// File: rtl/xc_aessub_unit.sv
// Sequential xc.aessub functional unit: latches the gathered operand bytes and
// substitutes LANES bytes per cycle, pulsing ready with the packed word.
module xc_aessub_unit
   import xc_aessub_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic         clock,
   input  logic         reset,
   xc_aessub_if.slave   bus
);

   localparam int STEPS = 4 / LANES;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("xc_aessub_unit: LANES must be 1, 2 or 4");
   end

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] ctr_q, ctr_d;
   byte4_t        opnd_q, opnd_d;
   byte4_t        acc_q, acc_d;
   logic          enc_q, enc_d;
   logic          rot_q, rot_d;
   logic          ready_q, ready_d;
   logic [31:0]   result_q, result_d;

   logic [1:0]    base;
   logic [7:0]    lane_in  [LANES];
   logic [7:0]    lane_out [LANES];
   byte4_t        acc_upd;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      xc_aessub_sbox u_sbox (
         .enc  (enc_q),
         .din  (lane_in[l]),
         .dout (lane_out[l])
      );
   end

   always_comb begin
      base    = 2'(32'(ctr_q) * LANES);
      acc_upd = acc_q;
      for (int l = 0; l < LANES; l++) begin
         lane_in[l]              = opnd_q[base + 2'(l)];
         acc_upd[base + 2'(l)]   = lane_out[l];
      end
   end

   always_comb begin
      state_d  = state_q;
      ctr_d    = ctr_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      enc_d    = enc_q;
      rot_d    = rot_q;
      ready_d  = 1'b0;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.valid) begin
               opnd_d  = gather(bus.rs1, bus.rs2);
               enc_d   = bus.enc;
               rot_d   = bus.rot;
               ctr_d   = '0;
               acc_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Pipeline withdrawing the request cancels the op without a pulse.
            if (!bus.valid) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = acc_upd;
               if (ctr_q == CW'(STEPS - 1)) begin
                  state_d  = ST_DONE;
                  ready_d  = 1'b1;
                  result_d = pack_rot(acc_upd, rot_q);
               end else begin
                  ctr_d = ctr_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ctr_q    <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         enc_q    <= 1'b0;
         rot_q    <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         ctr_q    <= ctr_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         enc_q    <= enc_d;
         rot_q    <= rot_d;
         ready_q  <= ready_d;
         result_q <= result_d;
      end
   end

   assign bus.ready  = ready_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_xc_aessub_unit.sv
// Bench for xc_aessub_unit at LANES=1,2,4: directed cases plus randomized ops
// against a table-based S-box reference built from field arithmetic.
module tb_xc_aessub_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_t [3];
   logic [31:0] rs1_t   [3];
   logic [31:0] rs2_t   [3];
   logic        enc_t   [3];
   logic        rot_t   [3];
   logic        ready_w [3];
   logic [31:0] result_w[3];

   int          n_chk = 0;
   int          n_err = 0;
   bit          in_done[3];
   logic [7:0]  sbox_tab[256];
   logic [7:0]  inv_tab [256];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      xc_aessub_if bus ();
      assign bus.valid = valid_t[g];
      assign bus.rs1   = rs1_t[g];
      assign bus.rs2   = rs2_t[g];
      assign bus.enc   = enc_t[g];
      assign bus.rot   = rot_t[g];
      assign ready_w[g]  = bus.ready;
      assign result_w[g] = bus.result;
      xc_aessub_unit #(.LANES(1 << g)) u_dut (
         .clock (clk),
         .reset (rst),
         .bus   (bus)
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int gmul(input int a, input int b);
      int p;
      p = 0;
      for (int i = 0; i < 8; i++) if ((b >> i) & 1) p = p ^ (a << i);
      for (int bit_i = 14; bit_i >= 8; bit_i--) if ((p >> bit_i) & 1) p = p ^ (32'h11B << (bit_i - 8));
      return p;
   endfunction

   function automatic int rotl8(input int x, input int k);
      return ((x << k) | (x >> (8 - k))) & 8'hFF;
   endfunction

   task automatic build_tables();
      int inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         if (x != 0) for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox_tab[x] = 8'(s);
         inv_tab[s]  = 8'(x);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic e, input logic r);
      logic [7:0]  t[4];
      logic [7:0]  u[4];
      logic [31:0] w;
      t[0] = a[7:0];  t[1] = b[15:8];  t[2] = a[23:16];  t[3] = b[31:24];
      for (int i = 0; i < 4; i++) u[i] = e ? sbox_tab[t[i]] : inv_tab[t[i]];
      w = {u[3], u[2], u[1], u[0]};
      if (r) w = {w[7:0], w[31:8]};
      return w;
   endfunction

   task automatic flush(input int g, input string tag);
      if (in_done[g]) begin
         valid_t[g] = 1'b0;
         @(posedge clk); #1;
         chk({tag, "_pulse"}, 32'(ready_w[g]), 32'd0);
         in_done[g] = 1'b0;
      end
   endtask

   // Latency counts edges from the accepting edge through the edge that raises ready.
   task automatic run_op(input int g, input logic [31:0] a, input logic [31:0] b,
                         input logic e, input logic r, input bit mutate, input bit hold,
                         input string tag, output logic [31:0] res);
      logic [31:0] exp;
      int          lat;
      bit          got;
      exp = model(a, b, e, r);
      rs1_t[g] = a;  rs2_t[g] = b;  enc_t[g] = e;  rot_t[g] = r;  valid_t[g] = 1'b1;
      if (in_done[g]) begin
         @(posedge clk); #1;
         chk({tag, "_pulse"}, 32'(ready_w[g]), 32'd0);
         in_done[g] = 1'b0;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 16) begin
         @(posedge clk); #1;
         lat++;
         got = ready_w[g];
         if (mutate && !got) begin
            rs1_t[g] = $urandom;  rs2_t[g] = $urandom;
            enc_t[g] = 1'($urandom);  rot_t[g] = 1'($urandom);
         end
      end
      res = result_w[g];
      chk({tag, "_lat"}, 32'(lat), 32'((4 >> g) + 1));
      chk({tag, "_res"}, res, exp);
      if (hold) in_done[g] = 1'b1;
      else begin
         in_done[g] = 1'b1;
         flush(g, tag);
      end
   endtask

   task automatic abort_op(input int g, input int k, input string tag);
      bit seen;
      flush(g, tag);
      rs1_t[g] = $urandom;  rs2_t[g] = $urandom;
      enc_t[g] = 1'($urandom);  rot_t[g] = 1'($urandom);
      valid_t[g] = 1'b1;
      seen = 1'b0;
      @(posedge clk); #1;
      repeat (k) begin
         @(posedge clk); #1;
         seen = seen | ready_w[g];
      end
      valid_t[g] = 1'b0;
      repeat ((4 >> g) + 2) begin
         @(posedge clk); #1;
         seen = seen | ready_w[g];
      end
      chk({tag, "_noready"}, 32'(seen), 32'd0);
   endtask

   initial begin
      logic [31:0] res;
      int          steps;
      for (int g = 0; g < 3; g++) begin
         valid_t[g] = 1'b0;  rs1_t[g] = '0;  rs2_t[g] = '0;
         enc_t[g] = 1'b0;  rot_t[g] = 1'b0;  in_done[g] = 1'b0;
      end
      build_tables();
      #12;
      for (int g = 0; g < 3; g++) begin
         chk("rst_ready", 32'(ready_w[g]), 32'd0);
         chk("rst_result", result_w[g], 32'd0);
      end
      #10 rst = 1'b0;
      @(posedge clk); #1;

      run_op(0, 32'h00530001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, "enc", res);
      chk("enc_const", res, 32'h63ED637C);
      run_op(0, 32'h00630063, 32'h7C000000, 1'b0, 1'b0, 1'b0, 1'b0, "dec", res);
      run_op(0, 32'h00530001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, "encrot", res);
      chk("encrot_const", res, 32'h7C63ED63);

      abort_op(0, 1, "abort");
      run_op(0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b0, 1'b0, "after_abort", res);

      run_op(0, 32'hDEADBEEF, 32'h01020304, 1'b1, 1'b0, 1'b1, 1'b1, "b2b_a", res);
      run_op(0, 32'hCAFEF00D, 32'h55AA33CC, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_b", res);

      rs1_t[0] = 32'h11223344;  rs2_t[0] = 32'h55667788;  enc_t[0] = 1'b1;  valid_t[0] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_ready", 32'(ready_w[0]), 32'd0);
      chk("midrst_result", result_w[0], 32'd0);
      valid_t[0] = 1'b0;
      #2 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_idle", 32'(ready_w[0]), 32'd0);
      run_op(0, 32'h00530001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, "post_rst", res);

      for (int g = 0; g < 3; g++) begin
         steps = 4 >> g;
         for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(7) == 0)
               abort_op(g, int'($urandom_range(steps - 1)), "rnd_abort");
            else
               run_op(g, $urandom, $urandom, 1'($urandom), 1'($urandom),
                      1'($urandom), ($urandom_range(2) == 0), "rnd", res);
         end
         flush(g, "rnd_end");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
